// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with fixed-priority next-PC selection,
// reset/trap vectors, relative branches, a circular return-address stack,
// a halt state and misaligned-target rejection.
module pc_gen #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h100),
    parameter int unsigned          INC          = 4,
    parameter int unsigned          ALIGN_BITS   = 2,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic            PC_clk,
    input  logic            PC_rst,
    input  logic            PC_stall,
    input  logic            PC_halt,
    input  logic            PC_trap,
    input  logic            PC_jump_enb,
    input  logic [XLEN-1:0] PC_jump_add,
    input  logic            PC_branch_enb,
    input  logic [XLEN-1:0] PC_branch_off,
    input  logic            PC_call,
    input  logic            PC_ret,
    output logic [XLEN-1:0] PC_counter,
    output logic            PC_valid,
    output logic            PC_misaligned,
    output logic            PC_ras_empty,
    output logic            PC_ras_full,
    output logic            PC_ras_under
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t          state, nxt_state;
    logic [XLEN-1:0] nxt_pc, pc_inc, ras_top, br_tgt;
    logic            nxt_mis, nxt_under, do_push, do_pop;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_wp, ras_top_idx, ras_wp_inc;
    logic [CW-1:0]   ras_cnt;

    assign pc_inc      = PC_counter + XLEN'(INC);
    assign br_tgt      = PC_counter + PC_branch_off;
    assign ras_top_idx = (ras_wp == '0) ? PW'(RAS_DEPTH - 1) : ras_wp - 1'b1;
    assign ras_wp_inc  = (ras_wp == PW'(RAS_DEPTH - 1)) ? '0 : ras_wp + 1'b1;
    assign ras_top     = ras_mem[ras_top_idx];

    assign PC_ras_empty = (ras_cnt == '0);
    assign PC_ras_full  = (ras_cnt == CW'(RAS_DEPTH));

    // Next-state / next-PC decode; halt sits just below trap and freezes the PC on the entry edge.
    always_comb begin
        nxt_state = state;
        nxt_pc    = PC_counter;
        nxt_mis   = 1'b0;
        nxt_under = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        unique case (state)
            S_BOOT: nxt_state = S_RUN;
            S_HALT: begin
                if (PC_trap) begin
                    nxt_state = S_RUN;
                    nxt_pc    = TRAP_VECTOR;
                end
            end
            S_RUN: begin
                if (PC_trap) begin
                    nxt_pc = TRAP_VECTOR;
                end else if (PC_halt) begin
                    nxt_state = S_HALT;
                end else if (PC_ret) begin
                    if (ras_cnt == '0) begin
                        nxt_pc    = pc_inc;
                        nxt_under = 1'b1;
                    end else begin
                        // rejected return still consumes its stack entry
                        do_pop = 1'b1;
                        if ((ras_top & ALIGN_MASK) != '0) begin
                            nxt_pc  = TRAP_VECTOR;
                            nxt_mis = 1'b1;
                        end else begin
                            nxt_pc = ras_top;
                        end
                    end
                end else if (PC_call || PC_jump_enb) begin
                    if ((PC_jump_add & ALIGN_MASK) != '0) begin
                        nxt_pc  = TRAP_VECTOR;
                        nxt_mis = 1'b1;
                    end else begin
                        nxt_pc  = PC_jump_add;
                        do_push = PC_call;
                    end
                end else if (PC_branch_enb) begin
                    if ((br_tgt & ALIGN_MASK) != '0) begin
                        nxt_pc  = TRAP_VECTOR;
                        nxt_mis = 1'b1;
                    end else begin
                        nxt_pc = br_tgt;
                    end
                end else if (!PC_stall) begin
                    nxt_pc = pc_inc;
                end
            end
            default: nxt_state = S_BOOT;
        endcase
    end

    // State, PC, registered flags and RAS pointer/count.
    always_ff @(posedge PC_clk or negedge PC_rst) begin
        if (!PC_rst) begin
            state         <= S_BOOT;
            PC_counter    <= RESET_VECTOR;
            PC_valid      <= 1'b0;
            PC_misaligned <= 1'b0;
            PC_ras_under  <= 1'b0;
            ras_wp        <= '0;
            ras_cnt       <= '0;
        end else begin
            state         <= nxt_state;
            PC_counter    <= nxt_pc;
            PC_valid      <= (nxt_state == S_RUN);
            PC_misaligned <= nxt_mis;
            PC_ras_under  <= nxt_under;
            if (do_push) begin
                // pushing onto a full stack overwrites the oldest entry
                ras_wp <= ras_wp_inc;
                if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
            end else if (do_pop) begin
                ras_wp  <= ras_top_idx;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    // Return-address storage; contents are only meaningful below ras_cnt.
    always_ff @(posedge PC_clk) begin
        if (PC_rst && do_push) ras_mem[ras_wp] <= pc_inc;
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen with a queue-based reference model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h100;
    localparam int DEPTH = 4;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

    logic        PC_clk = 1'b0;
    logic        PC_rst = 1'b0;
    logic        PC_stall = 0, PC_halt = 0, PC_trap = 0, PC_jump_enb = 0;
    logic        PC_branch_enb = 0, PC_call = 0, PC_ret = 0;
    logic [31:0] PC_jump_add = '0, PC_branch_off = '0;
    logic [31:0] PC_counter;
    logic        PC_valid, PC_misaligned, PC_ras_empty, PC_ras_full, PC_ras_under;

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4),
             .ALIGN_BITS(2), .RAS_DEPTH(DEPTH)) dut (
        .PC_clk(PC_clk), .PC_rst(PC_rst), .PC_stall(PC_stall), .PC_halt(PC_halt),
        .PC_trap(PC_trap), .PC_jump_enb(PC_jump_enb), .PC_jump_add(PC_jump_add),
        .PC_branch_enb(PC_branch_enb), .PC_branch_off(PC_branch_off),
        .PC_call(PC_call), .PC_ret(PC_ret), .PC_counter(PC_counter),
        .PC_valid(PC_valid), .PC_misaligned(PC_misaligned),
        .PC_ras_empty(PC_ras_empty), .PC_ras_full(PC_ras_full),
        .PC_ras_under(PC_ras_under)
    );

    always #5 PC_clk = ~PC_clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid, mis, under, empty, full;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // reference model state
    int          m_st = M_BOOT;
    logic [31:0] m_pc = RV;
    logic [31:0] m_ras[$];
    logic        m_mis = 0, m_under = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit bad_align(logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    // Apply the architectural rules to the inputs currently presented.
    function automatic void model_step();
        logic [31:0] t;
        m_mis = 0;
        m_under = 0;
        if (!PC_rst) begin
            m_st = M_BOOT; m_pc = RV; m_ras.delete();
        end else if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else if (m_st == M_HALT) begin
            if (PC_trap) begin m_st = M_RUN; m_pc = TV; end
        end else begin
            if (PC_trap) m_pc = TV;
            else if (PC_halt) m_st = M_HALT;
            else if (PC_ret) begin
                if (m_ras.size() == 0) begin m_pc = m_pc + 4; m_under = 1; end
                else begin
                    t = m_ras.pop_back();
                    if (bad_align(t)) begin m_pc = TV; m_mis = 1; end else m_pc = t;
                end
            end else if (PC_call || PC_jump_enb) begin
                if (bad_align(PC_jump_add)) begin m_pc = TV; m_mis = 1; end
                else begin
                    if (PC_call) begin
                        m_ras.push_back(m_pc + 4);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                    m_pc = PC_jump_add;
                end
            end else if (PC_branch_enb) begin
                t = m_pc + PC_branch_off;
                if (bad_align(t)) begin m_pc = TV; m_mis = 1; end else m_pc = t;
            end else if (!PC_stall) m_pc = m_pc + 4;
        end
    endfunction

    task automatic tick(string tag);
        exp_t e;
        model_step();
        e.pc = m_pc; e.valid = (m_st == M_RUN); e.mis = m_mis; e.under = m_under;
        e.empty = (m_ras.size() == 0); e.full = (m_ras.size() == DEPTH); e.tag = tag;
        sb.push_back(e);
        @(negedge PC_clk);
        PC_stall = 0; PC_halt = 0; PC_trap = 0; PC_jump_enb = 0;
        PC_branch_enb = 0; PC_call = 0; PC_ret = 0;
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic jump(logic [31:0] a, string tag);
        PC_jump_enb = 1; PC_jump_add = a; tick(tag);
    endtask

    // Monitor: compare every registered output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge PC_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".pc"},    PC_counter,    e.pc);
                check({e.tag, ".valid"}, 32'(PC_valid),      32'(e.valid));
                check({e.tag, ".mis"},   32'(PC_misaligned), 32'(e.mis));
                check({e.tag, ".under"}, 32'(PC_ras_under),  32'(e.under));
                check({e.tag, ".empty"}, 32'(PC_ras_empty),  32'(e.empty));
                check({e.tag, ".full"},  32'(PC_ras_full),   32'(e.full));
            end
        end
    end

    initial begin
        logic [31:0] r;
        @(negedge PC_clk);
        // T1 reset, boot, sequential run
        idle(2, "reset");
        PC_rst = 1;
        idle(5, "t1_seq");
        // T2 misaligned then aligned jump
        jump(32'h20, "t2_j20");
        jump(32'h1F5, "t2_mis");
        jump(32'h1F4, "t2_al");
        // T3 negative branch and wrap
        jump(32'h40, "t3_j40");
        PC_branch_enb = 1; PC_branch_off = -32'sd8; tick("t3_br");
        PC_branch_enb = 1; PC_branch_off = 32'h2; tick("t3_brmis");
        jump(32'hFFFF_FFFC, "t3_jtop");
        idle(2, "t3_wrap");
        // T4 RAS fill, overflow, LIFO drain, underflow
        jump(32'h10, "t4_j10");
        for (int i = 0; i < 5; i++) begin
            PC_call = 1; PC_jump_add = 32'h20 + 32'(i) * 32'h10; tick("t4_call");
        end
        PC_call = 1; PC_jump_add = 32'h1F6; tick("t4_callmis");
        for (int i = 0; i < 5; i++) begin
            PC_ret = 1; tick("t4_ret");
        end
        // T5 stall+jump, trap+halt, halt alone
        PC_stall = 1; PC_jump_enb = 1; PC_jump_add = 32'h300; tick("t5_stj");
        PC_stall = 1; idle(1, "t5_stall");
        PC_trap = 1; PC_halt = 1; tick("t5_trhalt");
        PC_halt = 1; tick("t5_halt");
        PC_jump_enb = 1; PC_jump_add = 32'h500; tick("t5_frozen");
        idle(2, "t5_frozen");
        PC_trap = 1; tick("t5_exit");
        idle(1, "t5_run");
        // T6 async reset during a call
        PC_call = 1; PC_jump_add = 32'h80; tick("t6_call");
        PC_call = 1; PC_jump_add = 32'h90; PC_rst = 0;
        #1;
        check("t6_async.pc", PC_counter, RV);
        check("t6_async.valid", 32'(PC_valid), 32'd0);
        check("t6_async.empty", 32'(PC_ras_empty), 32'd1);
        tick("t6_rst");
        PC_rst = 1;
        idle(2, "t6_rel");
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            PC_trap       = ($urandom_range(0, 99) < 3);
            PC_halt       = ($urandom_range(0, 99) < 2);
            PC_ret        = ($urandom_range(0, 99) < 12);
            PC_call       = ($urandom_range(0, 99) < 12);
            PC_jump_enb   = ($urandom_range(0, 99) < 8);
            PC_branch_enb = ($urandom_range(0, 99) < 12);
            PC_stall      = ($urandom_range(0, 99) < 15);
            r = $urandom();
            PC_jump_add = {r[31:2], 2'b00};
            if ($urandom_range(0, 9) == 0) PC_jump_add = PC_jump_add + $urandom_range(1, 3);
            PC_branch_off = 32'($urandom_range(0, 255)) * 4 - 32'd512;
            if ($urandom_range(0, 9) == 0) PC_branch_off = PC_branch_off + 1;
            PC_rst = ($urandom_range(0, 199) != 0);
            tick("rand");
            PC_rst = 1;
        end
        idle(1, "tail");
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
